aes128_enc_iter: RTL and testbench

//  Iterative AES-128 encryption core (FIPS-197 Cipher); forward counterpart of the existing combinational inverse cipher.

---
 rtl/aes128_enc_iter_pkg.sv | 62 ++++++
 rtl/aes128_enc_iter_if.sv | 23 ++
 rtl/aes_enc_round.sv | 39 +++
 rtl/aes128_enc_iter.sv | 134 +++++++++++++
 tb/tb_aes128_enc_iter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes128_enc_iter_pkg.sv
// Shared AES definitions: block/word types, FSM states, S-box table and
// GF(2^8) helpers. The inverse cipher path can import the same package.
package aes_pkg;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } enc_state_e;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Forward S-box, entry 0x00 in the most-significant byte.
  // NOTE: this is a constant lookup table, not storage, so it has no reset.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = int'(b);
    return SBOX_TBL[2047 - 8*idx -: 8];
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Byte i of a block; byte 0 is the most-significant byte (FIPS bit 0).
  function automatic logic [7:0] get_byte(input block_t blk, input int i);
    return blk[127 - 8*i -: 8];
  endfunction

endpackage

// File: rtl/aes128_enc_iter_if.sv
// Ready/valid bundle between the encryption core and its source/sink.
interface aes128_enc_iter_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t plaintext;
  block_t key;
  logic   out_valid;
  logic   out_ready;
  block_t ciphertext;
  logic   busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round:
// SubBytes -> ShiftRows -> MixColumns (bypassed on the last round) -> AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  block_t state_in,
  input  block_t round_key,
  input  logic   last,
  output block_t state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte i sits at row i%4, column i/4 of the AES state matrix.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(get_byte(state_in, i));
  end

  // Row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr[4*c + r] = sb[4*((c + r) % 4) + r];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[4*c + 0] = gmul2(sr[4*c]) ^ gmul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c + 1] = sr[4*c] ^ gmul2(sr[4*c+1]) ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
    assign mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
    assign mc[4*c + 3] = gmul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign state_out[127 - 8*i -: 8] = (last ? sr[i] : mc[i]) ^ get_byte(round_key, i);
  end

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one round per clock, round keys
// expanded on the fly, ready/valid handshake on input and output.
module aes128_enc_iter
  import aes_pkg::*;
#(
  parameter bit CLR_ON_DONE = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  aes128_enc_iter_if.slave bus
);

  enc_state_e state_q, state_d;

  block_t     state_reg;
  block_t     rk_reg;
  block_t     ct_reg;
  logic [7:0] rcon;
  logic [3:0] round_cnt;

  logic       in_ready;
  logic       out_valid;
  logic       busy;
  logic       accept;
  logic       out_fire;
  logic       last_round;

  word_t      w3_rot, w3_sub, temp;
  word_t      n0, n1, n2, n3;
  block_t     rk_next;
  block_t     round_out;

  // Key schedule for the next round key: RotWord/SubWord/rcon on w3, then the chain.
  assign w3_rot  = {rk_reg[23:0], rk_reg[31:24]};
  assign w3_sub  = {sbox(w3_rot[31:24]), sbox(w3_rot[23:16]),
                    sbox(w3_rot[15:8]),  sbox(w3_rot[7:0])};
  assign temp    = w3_sub ^ {rcon, 24'h000000};
  assign n0      = rk_reg[127:96] ^ temp;
  assign n1      = rk_reg[95:64]  ^ n0;
  assign n2      = rk_reg[63:32]  ^ n1;
  assign n3      = rk_reg[31:0]   ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  assign last_round = (round_cnt == LAST_ROUND);

  aes_enc_round u_round (
    .state_in  (state_reg),
    .round_key (rk_next),
    .last      (last_round),
    .state_out (round_out)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (last_round) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = in_ready && bus.in_valid;
  assign out_fire = out_valid && bus.out_ready;

  // Datapath: load on accept, one round per cycle, optional scrub on handoff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= '0;
      rk_reg    <= '0;
      ct_reg    <= '0;
      rcon      <= RCON_INIT;
      round_cnt <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_reg <= bus.plaintext ^ bus.key;
            rk_reg    <= bus.key;
            rcon      <= RCON_INIT;
            round_cnt <= 4'd1;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          rk_reg    <= rk_next;
          rcon      <= xtime(rcon);
          round_cnt <= round_cnt + 4'd1;
          if (last_round) ct_reg <= round_out;
        end
        DONE: begin
          if (out_fire) begin
            round_cnt <= '0;
            rcon      <= RCON_INIT;
            if (CLR_ON_DONE) begin
              state_reg <= '0;
              rk_reg    <= '0;
              ct_reg    <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.busy       = busy;
  assign bus.ciphertext = ct_reg;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Directed bench for aes128_enc_iter: FIPS-197 vectors, latency, backpressure,
// back-to-back streaming, mid-operation reset and output scrubbing.
module tb_aes128_enc_iter;
  import aes_pkg::*;

  localparam block_t K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam block_t CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam block_t K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block_t PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam block_t CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst_n;

  aes128_enc_iter_if bus ();
  aes128_enc_iter_if bus_h ();

  aes128_enc_iter #(.CLR_ON_DONE(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  aes128_enc_iter #(.CLR_ON_DONE(1'b0)) dut_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_h)
  );

  int n_checks = 0;
  int n_errors = 0;

  block_t ct;
  int     lat;
  int     acc_t [2];
  block_t cts [2];
  int     n_acc;
  int     n_out;
  int     seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish before 100us");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Bench-side reference for the inverse cipher (independent GF multiply).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] v);
    logic [7:0] res;
    res = 8'h00;
    for (int i = 0; i < 256; i++)
      if (sbox(8'(i)) == v) res = 8'(i);
    return res;
  endfunction

  function automatic block_t inv_cipher(input block_t c_in, input block_t k);
    logic [7:0] rk [0:10][0:15];
    logic [7:0] s [0:15];
    logic [7:0] t [0:15];
    logic [7:0] tmp [0:3];
    logic [7:0] rc, a0, a1, a2, a3;
    block_t     res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) rk[0][i] = k[127 - 8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      tmp[0] = sbox(rk[r-1][13]) ^ rc;
      tmp[1] = sbox(rk[r-1][14]);
      tmp[2] = sbox(rk[r-1][15]);
      tmp[3] = sbox(rk[r-1][12]);
      for (int j = 0; j < 4; j++)  rk[r][j] = rk[r-1][j] ^ tmp[j];
      for (int j = 4; j < 16; j++) rk[r][j] = rk[r-1][j] ^ rk[r][j-4];
      rc = gmul(rc, 8'h02);
    end
    for (int i = 0; i < 16; i++) s[i] = c_in[127 - 8*i -: 8] ^ rk[10][i];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c + row] = s[4*((c - row + 4) % 4) + row];
      for (int i = 0; i < 16; i++) s[i] = inv_sbox(t[i]) ^ rk[r][i];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // Called at a negedge with the core idle: accept one block, wait for out_valid.
  task automatic do_block(input block_t pt, input block_t k, output block_t c_out, output int edges);
    bus.in_valid  = 1'b1;
    bus.plaintext = pt;
    bus.key       = k;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    edges = 0;
    while (!bus.out_valid && edges < 30) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    c_out = bus.ciphertext;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.plaintext   = '0;
    bus.key         = '0;
    bus.out_ready   = 1'b0;
    bus_h.in_valid  = 1'b0;
    bus_h.plaintext = '0;
    bus_h.key       = '0;
    bus_h.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready",  128'(bus.in_ready),  128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_busy",      128'(bus.busy),      128'd0);
    check("rst_ct",        bus.ciphertext,      128'd0);
    check("rst_hold_ct",   bus_h.ciphertext,    128'd0);

    // 1: FIPS-197 App.B, latency
    do_block(PT1, K1, ct, lat);
    check("t1_ct",       ct,                  CT1);
    check("t1_latency",  128'(lat),           128'd10);
    check("t1_in_ready", 128'(bus.in_ready),  128'd0);
    check("t1_busy",     128'(bus.busy),      128'd1);
    handshake();
    check("t1_post_valid", 128'(bus.out_valid), 128'd0);
    check("t1_post_ready", 128'(bus.in_ready),  128'd1);
    check("t1_post_busy",  128'(bus.busy),      128'd0);

    // 2: FIPS-197 App.C.1, plus round trip through the inverse cipher
    do_block(PT2, K2, ct, lat);
    check("t2_ct",      ct,                 CT2);
    check("t2_latency", 128'(lat),          128'd10);
    check("t2_inverse", inv_cipher(ct, K2), PT2);
    handshake();
    check("t6_clr_ct", bus.ciphertext, 128'd0);

    // 3: backpressure with a competing in_valid
    do_block(PT1, K1, ct, lat);
    check("t3_ct", ct, CT1);
    bus.in_valid  = 1'b1;
    bus.plaintext = PT2;
    bus.key       = K2;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t3_ct_stable", bus.ciphertext,     CT1);
      check("t3_valid",     128'(bus.out_valid), 128'd1);
      check("t3_in_ready",  128'(bus.in_ready),  128'd0);
    end
    bus.in_valid = 1'b0;
    handshake();
    check("t3_post_valid", 128'(bus.out_valid), 128'd0);
    check("t3_post_ready", 128'(bus.in_ready),  128'd1);

    // 4: back-to-back with in_valid and out_ready tied high
    n_acc = 0;
    n_out = 0;
    bus.in_valid  = 1'b1;
    bus.plaintext = PT1;
    bus.key       = K1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && n_out < 2; c++) begin
      if (bus.in_ready && bus.in_valid && n_acc < 2) begin
        acc_t[n_acc] = c;
        n_acc++;
      end
      if (bus.out_valid && n_out < 2) begin
        cts[n_out] = bus.ciphertext;
        n_out++;
      end
      @(posedge clk);
      @(negedge clk);
      if (n_acc == 1) begin
        bus.plaintext = PT2;
        bus.key       = K2;
      end
      if (n_acc == 2) bus.in_valid = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("t4_accepts", 128'(n_acc), 128'd2);
    check("t4_outputs", 128'(n_out), 128'd2);
    if (n_out == 2) begin
      check("t4_ct1", cts[0], CT1);
      check("t4_ct2", cts[1], CT2);
    end
    if (n_acc == 2) check("t4_spacing", 128'(acc_t[1] - acc_t[0]), 128'd12);
    check("t4_idle_ready", 128'(bus.in_ready), 128'd1);

    // 5: reset during round 5
    bus.in_valid  = 1'b1;
    bus.plaintext = PT1;
    bus.key       = K1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_in_ready",  128'(bus.in_ready),  128'd1);
    check("t5_out_valid", 128'(bus.out_valid), 128'd0);
    check("t5_busy",      128'(bus.busy),      128'd0);
    check("t5_ct",        bus.ciphertext,      128'd0);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("t5_no_partial", 128'(seen), 128'd0);
    do_block(PT2, K2, ct, lat);
    check("t5_ct_after", ct,        CT2);
    check("t5_latency",  128'(lat), 128'd10);
    handshake();

    // 6: CLR_ON_DONE=0 keeps the last ciphertext in IDLE
    bus_h.in_valid  = 1'b1;
    bus_h.plaintext = PT2;
    bus_h.key       = K2;
    @(posedge clk);
    @(negedge clk);
    bus_h.in_valid = 1'b0;
    lat = 0;
    while (!bus_h.out_valid && lat < 30) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("t6_hold_latency", 128'(lat), 128'd10);
    check("t6_hold_ct", bus_h.ciphertext, CT2);
    bus_h.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_h.out_ready = 1'b0;
    check("t6_hold_valid",    128'(bus_h.out_valid), 128'd0);
    check("t6_hold_ready",    128'(bus_h.in_ready),  128'd1);
    check("t6_hold_ct_after", bus_h.ciphertext,      CT2);
    check("t6_clr_ct_final",  bus.ciphertext,        128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
